// File: rtl/serial_paralelo_if.sv
// -----------------------------------------------------------------------------
// serial_paralelo_if
//   Bundles the serial input and the byte-level outputs of the PHY receive lane.
//   Signals:
//     data_in     serial bit, MSB of each byte first
//     data_out    last received data byte
//     valid_out   data_out holds a non-comma byte received while active
//     byte_strobe one-cycle pulse per completed aligned byte
//     active      link aligned and active
//   Modports:
//     slave  - receiver side (serial_paralelo)
//     master - transmitter/consumer side (drives data_in, observes outputs)
// -----------------------------------------------------------------------------
interface serial_paralelo_if;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;

   modport slave  (input  data_in,
                   output data_out, valid_out, byte_strobe, active);
   modport master (output data_in,
                   input  data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/serial_paralelo.sv
// -----------------------------------------------------------------------------
// serial_paralelo
//   Serial-to-parallel receiver for one PCI PHY lane. Hunts bit by bit for the
//   COMMA symbol, then checks commas on byte boundaries; after BC_COUNT aligned
//   commas in a row the link is declared active and every non-comma byte is
//   presented on data_out with valid_out=1.
//   Ports:
//     clk_32f  in  bit clock, one serial bit per rising edge
//     reset    in  synchronous active-high reset
//     bus      slave modport: data_in (in), data_out/valid_out/byte_strobe/
//              active (out), all outputs registered
// -----------------------------------------------------------------------------
module serial_paralelo #(
   parameter logic [7:0] COMMA    = 8'hBC,
   parameter int         BC_COUNT = 4
) (
   input  logic               clk_32f,
   input  logic               reset,
   serial_paralelo_if.slave   bus
);

   typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;

   localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_sr;
   logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [3:0] r_bc_cnt,  w_bc_cnt_nxt;
   logic [7:0] r_data,    w_data_nxt;
   logic       r_valid,   w_valid_nxt;
   logic       r_strobe,  w_strobe_nxt;
   logic       r_active,  w_active_nxt;

   logic [7:0] w_nxt;
   logic       w_is_comma;
   logic       w_boundary;
   logic [3:0] w_bc_inc;

   // Shift register contents including the bit sampled on this edge.
   assign w_nxt      = {r_sr[6:0], bus.data_in};
   assign w_is_comma = (w_nxt == COMMA);
   assign w_boundary = (r_bit_cnt == 3'd7);
   assign w_bc_inc   = r_bc_cnt + 4'd1;

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         r_state   <= SEARCH;
         r_sr      <= 8'h00;
         r_bit_cnt <= 3'd0;
         r_bc_cnt  <= 4'd0;
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_strobe  <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sr      <= w_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_bc_cnt  <= w_bc_cnt_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_strobe  <= w_strobe_nxt;
         r_active  <= w_active_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;  // wraps 7 -> 0 naturally
      w_bc_cnt_nxt  = r_bc_cnt;
      w_data_nxt    = r_data;
      w_valid_nxt   = r_valid;
      w_strobe_nxt  = 1'b0;
      w_active_nxt  = r_active;

      unique case (r_state)
         SEARCH: begin
            // Bit-level hunt: any bit position may start a comma.
            if (w_is_comma) begin
               w_bit_cnt_nxt = 3'd0;
               w_bc_cnt_nxt  = 4'd1;
               w_strobe_nxt  = 1'b1;
               if (BC_TARGET == 4'd1) begin
                  w_state_nxt  = ACTIVE;
                  w_active_nxt = 1'b1;
               end else begin
                  w_state_nxt = SYNC;
               end
            end
         end
         SYNC: begin
            // Only boundary bytes matter; a comma inside a byte is ignored.
            if (w_boundary) begin
               w_strobe_nxt = 1'b1;
               if (w_is_comma) begin
                  w_bc_cnt_nxt = w_bc_inc;
                  if (w_bc_inc == BC_TARGET) begin
                     w_state_nxt  = ACTIVE;
                     w_active_nxt = 1'b1;
                  end
               end else begin
                  w_bc_cnt_nxt = 4'd0;
                  w_state_nxt  = SEARCH;
               end
            end
         end
         ACTIVE: begin
            // No loss-of-sync detection; only reset leaves this state.
            if (w_boundary) begin
               w_strobe_nxt = 1'b1;
               if (w_is_comma) begin
                  w_valid_nxt = 1'b0;
               end else begin
                  w_data_nxt  = w_nxt;
                  w_valid_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = SEARCH;
      endcase
   end

   assign bus.data_out    = r_data;
   assign bus.valid_out   = r_valid;
   assign bus.byte_strobe = r_strobe;
   assign bus.active      = r_active;

endmodule

// File: tb/tb_serial_paralelo.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo
//   Drives serial_paralelo bit by bit and compares every output after every
//   edge with a reference that tracks alignment as a cycle index (boundaries
//   are every 8th cycle after the aligning comma) and the last 8 received bits.
// -----------------------------------------------------------------------------
module tb_serial_paralelo;

   localparam logic [7:0] BC = 8'hBC;
   localparam int         NB = 4;

   logic clk_32f = 1'b0;
   logic reset;

   serial_paralelo_if bus ();

   serial_paralelo #(.COMMA(BC), .BC_COUNT(NB)) dut (
      .clk_32f (clk_32f),
      .reset   (reset),
      .bus     (bus.slave)
   );

   always #5 clk_32f = ~clk_32f;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: 0 = hunting, 1 = counting commas, 2 = active.
   int         m_mode   = 0;
   int         m_cyc    = 0;
   int         m_align  = 0;
   int         m_commas = 0;
   logic [7:0] m_hist   = 8'h00;
   logic [7:0] m_data   = 8'h00;
   logic       m_valid  = 1'b0;
   logic       m_strobe = 1'b0;
   logic       m_active = 1'b0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
      end
   endtask

   task automatic model(input logic r, input logic b);
      m_cyc++;
      m_strobe = 1'b0;
      if (r) begin
         m_mode = 0; m_commas = 0; m_hist = 8'h00;
         m_data = 8'h00; m_valid = 1'b0; m_active = 1'b0;
         return;
      end
      m_hist = {m_hist[6:0], b};
      if (m_mode == 0) begin
         if (m_hist == BC) begin
            m_align  = m_cyc;
            m_commas = 1;
            m_strobe = 1'b1;
            m_mode   = (NB == 1) ? 2 : 1;
            if (NB == 1) m_active = 1'b1;
         end
      end else if ((m_cyc - m_align) % 8 == 0) begin
         m_strobe = 1'b1;
         if (m_mode == 1) begin
            if (m_hist == BC) begin
               m_commas++;
               if (m_commas == NB) begin m_mode = 2; m_active = 1'b1; end
            end else begin
               m_commas = 0; m_mode = 0;
            end
         end else if (m_hist == BC) begin
            m_valid = 1'b0;
         end else begin
            m_data = m_hist; m_valid = 1'b1;
         end
      end
   endtask

   task automatic step(input logic r, input logic b);
      reset       = r;
      bus.data_in = b;
      @(posedge clk_32f);
      model(r, b);
      #1;
      chk("data_out",    bus.data_out,    m_data);
      chk("valid_out",   {7'd0, bus.valid_out},   {7'd0, m_valid});
      chk("byte_strobe", {7'd0, bus.byte_strobe}, {7'd0, m_strobe});
      chk("active",      {7'd0, bus.active},      {7'd0, m_active});
      if (bus.valid_out && !bus.active) chk("valid_while_inactive", 8'd1, 8'd0);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) step(1'b0, v[i]);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)));
   endtask

   logic [7:0] rb;

   initial begin
      reset       = 1'b1;
      bus.data_in = 1'b0;

      // 1: reset hold with random serial data.
      do_reset(5);
      chk("reset_data",   bus.data_out, 8'h00);
      chk("reset_active", {7'd0, bus.active}, 8'h00);

      // 2: junk bits, then four commas.
      step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      for (int k = 0; k < NB; k++) begin
         send_byte(BC);
         chk("bc_strobe", {7'd0, bus.byte_strobe}, 8'h01);
      end
      chk("active_after_4bc", {7'd0, bus.active}, 8'h01);
      chk("valid_after_4bc",  {7'd0, bus.valid_out}, 8'h00);

      // 3: data and an idle comma in between.
      send_byte(8'hCC); chk("d_cc", bus.data_out, 8'hCC); chk("v_cc", {7'd0, bus.valid_out}, 8'h01);
      send_byte(8'hAA); chk("d_aa", bus.data_out, 8'hAA);
      send_byte(BC);    chk("d_hold", bus.data_out, 8'hAA); chk("v_idle", {7'd0, bus.valid_out}, 8'h00);
      send_byte(8'hAA); chk("d_aa2", bus.data_out, 8'hAA); chk("v_aa2", {7'd0, bus.valid_out}, 8'h01);

      // 4: broken comma run returns to hunting.
      do_reset(2);
      step(1'b0, 1'b1);
      send_byte(BC); send_byte(BC); send_byte(8'h55);
      chk("no_active_55", {7'd0, bus.active}, 8'h00);
      for (int k = 0; k < NB - 1; k++) send_byte(BC);
      chk("no_active_3bc", {7'd0, bus.active}, 8'h00);
      send_byte(BC);
      chk("active_reacq", {7'd0, bus.active}, 8'h01);

      // 5: comma hidden across bytes 5E,0B aligns at bit 9.
      do_reset(2);
      rb = 8'h5E;
      for (int i = 7; i >= 0; i--) step(1'b0, rb[i]);
      chk("no_strobe_5e", {7'd0, bus.byte_strobe}, 8'h00);
      rb = 8'h0B;
      step(1'b0, rb[7]);
      chk("strobe_split_bc", {7'd0, bus.byte_strobe}, 8'h01);
      for (int i = 6; i >= 0; i--) step(1'b0, rb[i]);
      for (int k = 0; k < NB + 1; k++) send_byte(BC);
      chk("active_after_split", {7'd0, bus.active}, 8'h01);

      // Randomized traffic: junk offset, commas, random bytes.
      for (int t = 0; t < 6; t++) begin
         do_reset(1);
         for (int j = 0; j < $urandom_range(0, 11); j++) step(1'b0, 1'($urandom_range(0, 1)));
         for (int k = 0; k < NB + 1; k++) send_byte(BC);
         for (int k = 0; k < 24; k++) begin
            rb = ($urandom_range(0, 4) == 0) ? BC : 8'($urandom);
            send_byte(rb);
         end
         // 6: reset mid-byte while active, then reacquire.
         rb = 8'($urandom);
         for (int i = 7; i >= 4; i--) step(1'b0, rb[i]);
         step(1'b1, 1'($urandom_range(0, 1)));
         chk("midbyte_reset_active", {7'd0, bus.active}, 8'h00);
         chk("midbyte_reset_data",   bus.data_out, 8'h00);
         for (int k = 0; k < NB; k++) send_byte(BC);
         chk("reacq_after_reset", {7'd0, bus.active}, 8'h01);
         send_byte(8'h3C);
         chk("reacq_data", bus.data_out, 8'h3C);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
